dmem_access_unit: RTL and testbench

- Memory-stage load/store engine of the 4-stage core, directly downstream of the memory address forwarding select.
- Takes the X-stage memory instruction and picks the DMEM byte address from the ALU result or the forwarded M-stage value, per the address-forward select.
- Issues a registered request to DMEM with a ready handshake and returns aligned, sign/zero-extended load data.
- Generates the pipeline stall while DMEM is busy and flags misaligned accesses.

---
 rtl/dmem_access_unit.sv | 142 ++++++++++++++
 tb/tb_dmem_access_unit.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// Memory-stage load/store engine: selects the DMEM address, issues a registered
// request with a ready handshake, and returns aligned, extended load data.
module dmem_access_unit #(
  parameter int unsigned XLEN          = 32,
  parameter bit          MISALIGN_TRAP = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     inst_X,
  input  logic            valid_X,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] fwd_data,
  input  logic            addr_fwd,
  input  logic [XLEN-1:0] rs2_data,
  output logic            dmem_req,
  output logic [3:0]      dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ready,
  output logic            stall,
  output logic            load_valid,
  output logic [XLEN-1:0] load_data,
  output logic [4:0]      load_rd,
  output logic            misaligned
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q;
  logic            req_q, is_load_q, load_valid_q, misaligned_q;
  logic [3:0]      we_q;
  logic [XLEN-1:0] addr_q, wdata_q, load_data_q;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q;
  logic [4:0]      rd_q, load_rd_q;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            mem_op, is_load_x, mis_c, issue;
  logic [XLEN-1:0] addr_raw, addr_c, wdata_d;
  logic [1:0]      off_c;
  logic [3:0]      we_d;
  logic            unused_inst;

  assign opcode      = inst_X[6:0];
  assign funct3      = inst_X[14:12];
  assign unused_inst = ^inst_X[31:15];
  assign is_load_x   = (opcode == OP_LOAD);
  assign mem_op      = valid_X && (is_load_x || (opcode == OP_STORE));

  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] rdata,
                                                   input logic [1:0] off,
                                                   input logic [2:0] f3);
    logic [XLEN-1:0] s;
    s = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'b0, s[7:0]};
      3'b101:  return {16'b0, s[15:0]};
      default: return s;
    endcase
  endfunction

  always_comb begin
    addr_raw = addr_fwd ? fwd_data : alu_result;
    mis_c    = mem_op && (((funct3[1:0] == 2'b10) && (addr_raw[1:0] != 2'b00)) ||
                          ((funct3[1:0] == 2'b01) && addr_raw[0]));
    addr_c   = addr_raw;
    // Without trapping, a misaligned access is silently snapped down to its natural boundary.
    if (!MISALIGN_TRAP) begin
      if (funct3[1:0] == 2'b10)      addr_c[1:0] = 2'b00;
      else if (funct3[1:0] == 2'b01) addr_c[0]   = 1'b0;
    end
    off_c = addr_c[1:0];
    case (funct3[1:0])
      2'b00:   we_d = 4'b0001 << off_c;
      2'b01:   we_d = 4'b0011 << off_c;
      default: we_d = 4'b1111;
    endcase
    if (is_load_x) we_d = 4'b0000;
    wdata_d = rs2_data << {off_c, 3'b000};
  end

  assign stall = (state_q == BUSY) && !dmem_ready;
  assign issue = mem_op && !stall && !(mis_c && MISALIGN_TRAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      we_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      funct3_q     <= '0;
      off_q        <= '0;
      rd_q         <= '0;
      is_load_q    <= 1'b0;
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
      load_rd_q    <= '0;
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= MISALIGN_TRAP && mis_c && !stall;
      load_valid_q <= 1'b0;
      if ((state_q == BUSY) && dmem_ready && is_load_q) begin
        load_valid_q <= 1'b1;
        load_data_q  <= load_extract(dmem_rdata, off_q, funct3_q);
        load_rd_q    <= rd_q;
      end
      // A new access may be captured on the same edge the outstanding one completes.
      if (issue) begin
        state_q   <= BUSY;
        req_q     <= 1'b1;
        addr_q    <= addr_c;
        we_q      <= we_d;
        wdata_q   <= wdata_d;
        funct3_q  <= funct3;
        off_q     <= off_c;
        rd_q      <= inst_X[11:7];
        is_load_q <= is_load_x;
      end else if ((state_q == BUSY) && dmem_ready) begin
        state_q <= IDLE;
        req_q   <= 1'b0;
      end
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign load_valid = load_valid_q;
  assign load_data  = load_data_q;
  assign load_rd    = load_rd_q;
  assign misaligned = misaligned_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: byte-level memory model predicts requests,
// load results, misaligned pulses and stall; monitors compare what the DUT presents.
module tb_dmem_access_unit;

  localparam logic [6:0] OP_L = 7'h03;
  localparam logic [6:0] OP_S = 7'h23;
  localparam logic [6:0] OP_R = 7'h33;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_X, alu_result, fwd_data, rs2_data, dmem_rdata;
  logic        valid_X, addr_fwd, dmem_ready;
  logic        dmem_req, stall, load_valid, misaligned;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, load_data;
  logic [4:0]  load_rd;

  always #5 clk = ~clk;

  dmem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .inst_X(inst_X), .valid_X(valid_X),
    .alu_result(alu_result), .fwd_data(fwd_data), .addr_fwd(addr_fwd),
    .rs2_data(rs2_data), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .stall(stall), .load_valid(load_valid),
    .load_data(load_data), .load_rd(load_rd), .misaligned(misaligned)
  );

  typedef struct { logic [31:0] addr; logic [3:0] we; logic [31:0] wdata; logic is_store; } req_t;
  typedef struct { logic [31:0] data; logic [4:0] rd; } ld_t;

  req_t        req_q[$];
  ld_t         ld_q[$];
  int          mis_q[$];
  int          errors = 0;
  int          checks = 0;
  logic        outstanding = 1'b0;
  logic        last_consumed;
  logic [7:0]  mdl_b[int];
  logic [31:0] rsp_w[int];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int w);
    logic [31:0] wu;
    wu = w;
    return (wu * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [7:0] mdl_rd(input logic [31:0] a);
    logic [31:0] w;
    if (mdl_b.exists(int'(a))) return mdl_b[int'(a)];
    w = init_word(int'(a >> 2));
    return w[8*a[1:0] +: 8];
  endfunction

  function automatic logic [31:0] rsp_rd(input int w);
    return rsp_w.exists(w) ? rsp_w[w] : init_word(w);
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
    return {17'b0, f3, rd, op};
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] val);
    for (int b = 0; b < 4; b++) mdl_b[int'(a) + b] = val[8*b +: 8];
    rsp_w[int'(a >> 2)] = val;
  endtask

  // One clock of stimulus: memory responder, model prediction, stall check.
  task automatic step(input logic [31:0] inst, input logic vld, input logic [31:0] alu,
                      input logic [31:0] fwd, input logic af, input logic [31:0] rs2,
                      input logic rdy);
    logic [31:0] a, cur, val, wd;
    logic [3:0]  we;
    logic [2:0]  f3;
    logic        exp_stall, memop, issued, is_ld;
    int          n, w, off;
    @(negedge clk);
    inst_X = inst; valid_X = vld; alu_result = alu; fwd_data = fwd;
    addr_fwd = af; rs2_data = rs2; dmem_ready = rdy;
    if (dmem_req && rdy) begin
      w   = int'(dmem_addr >> 2);
      cur = rsp_rd(w);
      dmem_rdata = cur;
      if (|dmem_we) begin
        for (int b = 0; b < 4; b++) if (dmem_we[b]) cur[8*b +: 8] = dmem_wdata[8*b +: 8];
        rsp_w[w] = cur;
      end
    end else begin
      dmem_rdata = $urandom;
    end
    #1;
    exp_stall = outstanding && !rdy;
    chk("stall", {31'b0, stall}, {31'b0, exp_stall});
    is_ld  = (inst[6:0] == OP_L);
    memop  = vld && (is_ld || inst[6:0] == OP_S);
    f3     = inst[14:12];
    n      = 1 << f3[1:0];
    a      = af ? fwd : alu;
    off    = int'(a[1:0]);
    issued = 1'b0;
    last_consumed = !(memop && exp_stall);
    if (memop && !exp_stall) begin
      if (off % n != 0) begin
        mis_q.push_back(1);
      end else if (is_ld) begin
        issued = 1'b1;
        val = '0;
        for (int b = 0; b < n; b++) val[8*b +: 8] = mdl_rd(a + b);
        if (n < 4 && !f3[2] && val[8*n-1])
          for (int b = n; b < 4; b++) val[8*b +: 8] = 8'hFF;
        ld_q.push_back('{data: val, rd: inst[11:7]});
        req_q.push_back('{addr: a, we: 4'b0000, wdata: 32'h0, is_store: 1'b0});
      end else begin
        issued = 1'b1;
        we = 4'b0000;
        for (int b = 0; b < n; b++) begin
          we[off + b] = 1'b1;
          mdl_b[int'(a) + b] = rs2[8*b +: 8];
        end
        wd = rs2 << (8 * off);
        req_q.push_back('{addr: a, we: we, wdata: wd, is_store: 1'b1});
      end
    end
    if (issued) outstanding = 1'b1;
    else if (rdy) outstanding = 1'b0;
  endtask

  task automatic nop(input logic rdy);
    step(mk(OP_R, 3'b000, 5'd0), 1'b1, 32'h0, 32'h0, 1'b0, 32'h0, rdy);
  endtask

  task automatic dload(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] exp);
    step(mk(OP_L, f3, rd), 1'b1, a, 32'h0, 1'b0, 32'h0, 1'b1);
    nop(1'b1);
    @(posedge clk); #1;
    chk("dload_valid", {31'b0, load_valid}, 32'h1);
    chk("dload_data", load_data, exp);
    chk("dload_rd", {27'b0, load_rd}, {27'b0, rd});
  endtask

  task automatic dstore(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rs2,
                        input logic [3:0] exp_we, input logic [31:0] exp_wd);
    step(mk(OP_S, f3, 5'd0), 1'b1, a, 32'h0, 1'b0, rs2, 1'b1);
    @(posedge clk); #1;
    chk("dstore_req", {31'b0, dmem_req}, 32'h1);
    chk("dstore_addr", dmem_addr, a);
    chk("dstore_we", {28'b0, dmem_we}, {28'b0, exp_we});
    chk("dstore_wdata", dmem_wdata, exp_wd);
    nop(1'b1);
  endtask

  // Request monitor: one comparison per accepted request.
  always @(negedge clk) begin
    req_t r;
    #2;
    if (rst_n && dmem_req && dmem_ready) begin
      chk("req_pending", {31'b0, (req_q.size() != 0)}, 32'h1);
      if (req_q.size() != 0) begin
        r = req_q.pop_front();
        chk("req_addr", dmem_addr, r.addr);
        chk("req_we", {28'b0, dmem_we}, {28'b0, r.we});
        if (r.is_store) chk("req_wdata", dmem_wdata, r.wdata);
      end
    end
  end

  // Result monitor: load completions and misaligned pulses.
  always @(posedge clk) begin
    ld_t l;
    #1;
    if (rst_n) begin
      if (load_valid) begin
        chk("load_pending", {31'b0, (ld_q.size() != 0)}, 32'h1);
        if (ld_q.size() != 0) begin
          l = ld_q.pop_front();
          chk("load_data", load_data, l.data);
          chk("load_rd", {27'b0, load_rd}, {27'b0, l.rd});
        end
      end
      if (misaligned) begin
        chk("mis_pending", {31'b0, (mis_q.size() != 0)}, 32'h1);
        if (mis_q.size() != 0) void'(mis_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] ri, ra, ro, rs;
    logic        rv, rf, have;
    logic [2:0]  f3;
    int          k;
    logic [2:0]  lf3[5];
    lf3[0] = 3'b000; lf3[1] = 3'b001; lf3[2] = 3'b010; lf3[3] = 3'b100; lf3[4] = 3'b101;
    rst_n = 1'b0; inst_X = '0; valid_X = 1'b0; alu_result = '0; fwd_data = '0;
    addr_fwd = 1'b0; rs2_data = '0; dmem_rdata = '0; dmem_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'b0, dmem_req}, 32'h0);
    chk("rst_we", {28'b0, dmem_we}, 32'h0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_lvalid", {31'b0, load_valid}, 32'h0);
    chk("rst_ldata", load_data, 32'h0);
    chk("rst_lrd", {27'b0, load_rd}, 32'h0);
    chk("rst_mis", {31'b0, misaligned}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    rst_n = 1'b1;

    // Word store, then back to idle
    dstore(3'b010, 32'h104, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
    @(posedge clk); #1;
    chk("sw_idle", {31'b0, dmem_req}, 32'h0);

    // Sub-word loads with sign/zero extension
    preload(32'h200, 32'h80FF1234);
    dload(3'b000, 5'd11, 32'h203, 32'hFFFFFF80);
    dload(3'b100, 5'd12, 32'h203, 32'h00000080);
    dload(3'b001, 5'd13, 32'h202, 32'hFFFF80FF);

    // Sub-word stores
    dstore(3'b000, 32'h101, 32'h000000AB, 4'b0010, 32'h0000AB00);
    dstore(3'b001, 32'h102, 32'h00001234, 4'b1100, 32'h12340000);

    // Load held off by three not-ready cycles
    step(mk(OP_L, 3'b010, 5'd9), 1'b1, 32'h120, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (3) begin
      nop(1'b0);
      @(posedge clk); #1;
      chk("wait_stall", {31'b0, stall}, 32'h1);
      chk("wait_addr", dmem_addr, 32'h120);
      chk("wait_we", {28'b0, dmem_we}, 32'h0);
      chk("wait_lvalid", {31'b0, load_valid}, 32'h0);
    end
    nop(1'b1);
    @(posedge clk); #1;
    chk("wait_done", {31'b0, load_valid}, 32'h1);
    @(posedge clk); #1;
    chk("wait_once", {31'b0, load_valid}, 32'h0);

    // Misaligned accesses
    step(mk(OP_L, 3'b010, 5'd3), 1'b1, 32'h102, 32'h0, 1'b0, 32'h0, 1'b1);
    @(posedge clk); #1;
    chk("mis_lw", {31'b0, misaligned}, 32'h1);
    chk("mis_lw_req", {31'b0, dmem_req}, 32'h0);
    step(mk(OP_L, 3'b001, 5'd3), 1'b1, 32'h101, 32'h0, 1'b0, 32'h0, 1'b1);
    @(posedge clk); #1;
    chk("mis_lh", {31'b0, misaligned}, 32'h1);
    chk("mis_lh_req", {31'b0, dmem_req}, 32'h0);
    step(mk(OP_L, 3'b001, 5'd3), 1'b1, 32'h102, 32'h0, 1'b0, 32'h0, 1'b1);
    @(posedge clk); #1;
    chk("ok_lh_mis", {31'b0, misaligned}, 32'h0);
    chk("ok_lh_req", {31'b0, dmem_req}, 32'h1);
    chk("ok_lh_addr", dmem_addr, 32'h102);
    nop(1'b1);

    // Load followed back-to-back by a store using the forwarded address
    step(mk(OP_L, 3'b010, 5'd7), 1'b1, 32'h140, 32'h0, 1'b0, 32'h0, 1'b1);
    step(mk(OP_S, 3'b010, 5'd0), 1'b1, 32'h144, 32'h300, 1'b1, 32'h11223344, 1'b1);
    @(posedge clk); #1;
    chk("fwd_req", {31'b0, dmem_req}, 32'h1);
    chk("fwd_addr", dmem_addr, 32'h300);
    chk("fwd_we", {28'b0, dmem_we}, 32'hF);
    chk("fwd_lvalid", {31'b0, load_valid}, 32'h1);
    nop(1'b1);
    nop(1'b1);

    // Randomized traffic with a random ready pattern
    have = 1'b0;
    ri = '0; rv = 1'b0; ra = '0; ro = '0; rf = 1'b0; rs = '0;
    repeat (600) begin
      if (!have) begin
        k  = $urandom_range(0, 9);
        f3 = (k < 4 || k == 8) ? lf3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
        ri = mk((k < 4 || k == 8) ? OP_L : (k < 7 ? OP_S : OP_R), f3, 5'($urandom_range(0, 31)));
        rv = (k != 8);
        ra = 32'h100 + $urandom_range(0, 63);
        if ($urandom_range(0, 1) == 1) ra[1:0] = ra[1:0] & ~((2'b01 << f3[1:0]) - 2'b01);
        ro = 32'h100 + $urandom_range(0, 63);
        rf = 1'($urandom_range(0, 1));
        rs = $urandom;
      end
      step(ri, rv, rf ? ro : ra, rf ? ra : ro, rf, rs, ($urandom_range(0, 3) != 0));
      have = !last_consumed;
    end
    repeat (3) nop(1'b1);

    // Reset while a load is outstanding
    step(mk(OP_L, 3'b010, 5'd5), 1'b1, 32'h130, 32'h0, 1'b0, 32'h0, 1'b0);
    nop(1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, dmem_req}, 32'h0);
    chk("arst_lvalid", {31'b0, load_valid}, 32'h0);
    req_q.delete(); ld_q.delete(); mis_q.delete();
    outstanding = 1'b0;
    nop(1'b1);
    nop(1'b1);
    rst_n = 1'b1;
    repeat (4) nop(1'b1);

    chk("req_q_drained", req_q.size(), 32'h0);
    chk("ld_q_drained", ld_q.size(), 32'h0);
    chk("mis_q_drained", mis_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
